alu_result_stage: RTL and testbench

- Registered result stage directly downstream of the ALU. Captures the ALU's combinational HI/LO result and opcode into a small FIFO. Presents the head entry as the Z register pair (zhigh/zlow) to the bus/writeback logic through a valid/ready handshake.
- On retirement of a mul/div result, it updates the architectural HI and LO special registers. On retirement of every other ALU op, it updates the condition flags (zero, negative).

---
 rtl/alu_ops_pkg.sv | 32 +++
 rtl/alu_result_stage_if.sv | 27 ++
 rtl/alu_result_stage_result_fifo.sv | 58 +++++
 rtl/alu_result_stage.sv | 60 ++++++
 tb/tb_alu_result_stage.sv | 188 ++++++++++++++++++
 5 files changed

// File: rtl/alu_ops_pkg.sv
// ALU opcode encodings and retirement predicates, imported by the ALU and its result stage.
package alu_ops_pkg;

    localparam int unsigned OP_W = 5;

    localparam logic [OP_W-1:0] _add  = 5'b00011;
    localparam logic [OP_W-1:0] _sub  = 5'b00100;
    localparam logic [OP_W-1:0] _and  = 5'b00101;
    localparam logic [OP_W-1:0] _or   = 5'b00110;
    localparam logic [OP_W-1:0] _shr  = 5'b00111;
    localparam logic [OP_W-1:0] _shra = 5'b01000;
    localparam logic [OP_W-1:0] _shl  = 5'b01001;
    localparam logic [OP_W-1:0] _ror  = 5'b01010;
    localparam logic [OP_W-1:0] _rol  = 5'b01011;
    localparam logic [OP_W-1:0] _addi = 5'b01100;
    localparam logic [OP_W-1:0] _andi = 5'b01101;
    localparam logic [OP_W-1:0] _ori  = 5'b01110;
    localparam logic [OP_W-1:0] _mul  = 5'b01111;
    localparam logic [OP_W-1:0] _div  = 5'b10000;
    localparam logic [OP_W-1:0] _neg  = 5'b10001;
    localparam logic [OP_W-1:0] _not  = 5'b10010;

    // mul/div produce a 2-word result destined for the HI/LO special registers
    function automatic logic is_muldiv(input logic [OP_W-1:0] op);
        return (op == _mul) || (op == _div);
    endfunction

    function automatic logic sets_flags(input logic [OP_W-1:0] op);
        return ((op >= _add) && (op <= _ori)) || (op == _neg) || (op == _not);
    endfunction

endpackage

// File: rtl/alu_result_stage_if.sv
// ALU-to-result-stage and result-stage-to-bus handshakes; master is the control/datapath side.
interface alu_result_stage_if #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned OPW   = 5
);
    logic             in_valid;
    logic             in_ready;
    logic [OPW-1:0]   in_op;
    logic [WIDTH-1:0] in_hi;
    logic [WIDTH-1:0] in_lo;
    logic             flush;
    logic             z_valid;
    logic             z_ready;
    logic [OPW-1:0]   z_op;
    logic [WIDTH-1:0] zhigh;
    logic [WIDTH-1:0] zlow;

    modport master (
        output in_valid, in_op, in_hi, in_lo, flush, z_ready,
        input  in_ready, z_valid, z_op, zhigh, zlow
    );

    modport slave (
        input  in_valid, in_op, in_hi, in_lo, flush, z_ready,
        output in_ready, z_valid, z_op, zhigh, zlow
    );
endinterface

// File: rtl/alu_result_stage_result_fifo.sv
// Generic valid/ready FIFO with synchronous flush and exact occupancy count.
module result_fifo #(
    parameter int unsigned WIDTH_TOTAL = 69,
    parameter int unsigned DEPTH       = 2
) (
    input  logic                       clk,
    input  logic                       clr,
    input  logic                       flush,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [WIDTH_TOTAL-1:0]     in_data,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [WIDTH_TOTAL-1:0]     out_data,
    output logic [$clog2(DEPTH):0]     count
);
    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = AW + 1;

    logic [WIDTH_TOTAL-1:0] mem [DEPTH];
    logic [AW-1:0]          head;
    logic [AW-1:0]          tail;
    logic                   push;
    logic                   pop;

    // clr gates in_ready so nothing is offered as accepted while held in reset
    assign in_ready  = (count < CW'(DEPTH)) && !flush && clr;
    assign out_valid = (count != '0);
    assign out_data  = mem[head];
    assign push      = in_valid && in_ready;
    assign pop       = out_valid && out_ready && !flush;

    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else if (flush) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else begin
            if (push) tail <= tail + AW'(1);
            if (pop)  head <= head + AW'(1);
            case ({push, pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

    // storage carries no reset; entries are qualified by count
    always_ff @(posedge clk) begin
        if (push) mem[tail] <= in_data;
    end

endmodule

// File: rtl/alu_result_stage.sv
// ALU result stage: queues HI/LO/op results as the Z pair and applies HI/LO/flag updates at retirement.
module alu_result_stage
    import alu_ops_pkg::*;
#(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned DEPTH = 2,
    parameter int unsigned OPW   = 5
) (
    input  logic                   clk,
    input  logic                   clr,
    alu_result_stage_if.slave      bus,
    output logic [WIDTH-1:0]       hi_q,
    output logic [WIDTH-1:0]       lo_q,
    output logic                   flag_z,
    output logic                   flag_n,
    output logic [$clog2(DEPTH):0] count
);
    localparam int unsigned WT = 2 * WIDTH + OPW;

    logic [WT-1:0] head_data;
    logic          retire;

    result_fifo #(.WIDTH_TOTAL(WT), .DEPTH(DEPTH)) u_fifo (
        .clk       (clk),
        .clr       (clr),
        .flush     (bus.flush),
        .in_valid  (bus.in_valid),
        .in_ready  (bus.in_ready),
        .in_data   ({bus.in_op, bus.in_hi, bus.in_lo}),
        .out_valid (bus.z_valid),
        .out_ready (bus.z_ready),
        .out_data  (head_data),
        .count     (count)
    );

    assign bus.z_op  = head_data[WT-1 -: OPW];
    assign bus.zhigh = head_data[2*WIDTH-1 -: WIDTH];
    assign bus.zlow  = head_data[WIDTH-1:0];

    // a flush-coincident pop is discarded, so it must not retire either
    assign retire = bus.z_valid && bus.z_ready && !bus.flush;

    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            hi_q   <= '0;
            lo_q   <= '0;
            flag_z <= 1'b0;
            flag_n <= 1'b0;
        end else if (retire) begin
            if (is_muldiv(OP_W'(bus.z_op))) begin
                hi_q <= bus.zhigh;
                lo_q <= bus.zlow;
            end else if (sets_flags(OP_W'(bus.z_op))) begin
                flag_z <= (bus.zlow == '0);
                flag_n <= bus.zlow[WIDTH-1];
            end
        end
    end

endmodule

// File: tb/tb_alu_result_stage.sv
// Randomized and directed bench for alu_result_stage against a queue-based reference model.
module tb_alu_result_stage;
    localparam int unsigned WIDTH = 32;
    localparam int unsigned DEPTH = 2;
    localparam int unsigned OPW   = 5;

    typedef struct packed {
        logic [4:0]  op;
        logic [31:0] hi;
        logic [31:0] lo;
    } entry_t;

    logic        clk = 1'b0;
    logic        clr;
    logic [31:0] hi_q, lo_q;
    logic        flag_z, flag_n;
    logic [1:0]  count;

    int n_checks = 0;
    int n_errors = 0;

    entry_t      mq[$];
    logic [31:0] m_hi, m_lo;
    logic        m_z, m_n;

    alu_result_stage_if #(.WIDTH(WIDTH), .OPW(OPW)) bus ();

    alu_result_stage #(.WIDTH(WIDTH), .DEPTH(DEPTH), .OPW(OPW)) dut (
        .clk    (clk),
        .clr    (clr),
        .bus    (bus.slave),
        .hi_q   (hi_q),
        .lo_q   (lo_q),
        .flag_z (flag_z),
        .flag_n (flag_n),
        .count  (count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        mq.delete();
        m_hi = '0; m_lo = '0; m_z = 1'b0; m_n = 1'b0;
    endtask

    // One clock: drive, compare against model before the edge, then advance the model.
    task automatic cycle(input bit v, input logic [4:0] op, input logic [31:0] hi,
                         input logic [31:0] lo, input bit zr, input bit fl);
        entry_t e;
        bit     do_push, do_pop;
        bus.in_valid = v; bus.in_op = op; bus.in_hi = hi; bus.in_lo = lo;
        bus.z_ready = zr; bus.flush = fl;
        #1;
        chk("in_ready", 64'(bus.in_ready), 64'(mq.size() < DEPTH && !fl));
        chk("z_valid",  64'(bus.z_valid),  64'(mq.size() != 0));
        chk("count",    64'(count),        64'(mq.size()));
        if (mq.size() != 0) begin
            chk("z_op",  64'(bus.z_op),  64'(mq[0].op));
            chk("zhigh", 64'(bus.zhigh), 64'(mq[0].hi));
            chk("zlow",  64'(bus.zlow),  64'(mq[0].lo));
        end
        chk("hi_q",   64'(hi_q),   64'(m_hi));
        chk("lo_q",   64'(lo_q),   64'(m_lo));
        chk("flag_z", 64'(flag_z), 64'(m_z));
        chk("flag_n", 64'(flag_n), 64'(m_n));
        @(posedge clk);
        if (fl) begin
            mq.delete();
        end else begin
            do_push = v && (mq.size() < DEPTH);
            do_pop  = zr && (mq.size() != 0);
            if (do_pop) begin
                e = mq.pop_front();
                if (e.op == 5'd15 || e.op == 5'd16) begin
                    m_hi = e.hi; m_lo = e.lo;
                end else if ((e.op >= 5'd3 && e.op <= 5'd14) || e.op == 5'd17 || e.op == 5'd18) begin
                    m_z = (e.lo == 32'd0); m_n = e.lo[31];
                end
            end
            if (do_push) mq.push_back('{op: op, hi: hi, lo: lo});
        end
        @(negedge clk);
    endtask

    task automatic idle();
        cycle(1'b0, 5'd0, 32'd0, 32'd0, 1'b0, 1'b0);
    endtask

    task automatic pop1();
        cycle(1'b0, 5'd0, 32'd0, 32'd0, 1'b1, 1'b0);
    endtask

    initial begin
        logic [4:0] rop;
        bus.in_valid = 1'b0; bus.in_op = '0; bus.in_hi = '0; bus.in_lo = '0;
        bus.z_ready = 1'b0; bus.flush = 1'b0;
        clr = 1'b0;
        model_reset();
        #2;
        chk("rst_in_ready", 64'(bus.in_ready), 64'd0);
        chk("rst_count",    64'(count),        64'd0);
        chk("rst_z_valid",  64'(bus.z_valid),  64'd0);
        @(negedge clk);
        clr = 1'b1;
        idle();

        // add lo=5, then pop: flags clear, hi_q untouched
        cycle(1'b1, 5'b00011, 32'd0, 32'd5, 1'b0, 1'b0);
        pop1();
        idle();

        // mul hi=1 lo=8000_0000 updates HI/LO only
        cycle(1'b1, 5'b01111, 32'd1, 32'h8000_0000, 1'b0, 1'b0);
        pop1();
        idle();
        chk("mul_hi", 64'(hi_q), 64'd1);
        chk("mul_lo", 64'(lo_q), 64'h8000_0000);

        // fill to DEPTH with z_ready=0; third push must be refused
        cycle(1'b1, 5'b00100, 32'd0, 32'd0, 1'b0, 1'b0);
        cycle(1'b1, 5'b10010, 32'd0, 32'hFFFF_FFFE, 1'b0, 1'b0);
        cycle(1'b1, 5'b00011, 32'd9, 32'd9, 1'b0, 1'b0);
        pop1();
        chk("sub_fz", 64'(flag_z), 64'd1);
        pop1();
        idle();
        chk("not_fn", 64'(flag_n), 64'd1);

        // simultaneous push (div) and pop (or) at count=1
        cycle(1'b1, 5'b00110, 32'd0, 32'h10, 1'b0, 1'b0);
        cycle(1'b1, 5'b10000, 32'd3, 32'd7, 1'b1, 1'b0);
        chk("simul_count", 64'(count), 64'd1);
        pop1();
        idle();
        chk("div_hi", 64'(hi_q), 64'd3);
        chk("div_lo", 64'(lo_q), 64'd7);

        // flush at count=2 with a mul at the head being popped
        cycle(1'b1, 5'b01111, 32'hAA, 32'hBB, 1'b0, 1'b0);
        cycle(1'b1, 5'b00011, 32'd1, 32'd1, 1'b0, 1'b0);
        cycle(1'b0, 5'd0, 32'd0, 32'd0, 1'b1, 1'b1);
        idle();
        chk("flush_hi", 64'(hi_q), 64'd3);
        chk("flush_count", 64'(count), 64'd0);

        // asynchronous clr mid-fill, checked before any clock edge
        cycle(1'b1, 5'b01111, 32'h55, 32'h66, 1'b0, 1'b0);
        cycle(1'b1, 5'b00011, 32'd0, 32'h8000_0001, 1'b1, 1'b0);
        pop1();
        clr = 1'b0;
        #1;
        chk("aclr_z_valid",  64'(bus.z_valid),  64'd0);
        chk("aclr_count",    64'(count),        64'd0);
        chk("aclr_in_ready", 64'(bus.in_ready), 64'd0);
        chk("aclr_hi",       64'(hi_q),         64'd0);
        chk("aclr_lo",       64'(lo_q),         64'd0);
        chk("aclr_fn",       64'(flag_n),       64'd0);
        model_reset();
        @(negedge clk);
        clr = 1'b1;
        idle();

        // random traffic across all op classes
        for (int i = 0; i < 400; i++) begin
            case ($urandom_range(0, 3))
                0:       rop = 5'($urandom_range(15, 16));
                1:       rop = 5'($urandom_range(3, 14));
                2:       rop = 5'($urandom_range(17, 18));
                default: rop = 5'($urandom_range(0, 31));
            endcase
            cycle(1'($urandom_range(0, 1)), rop, $urandom(),
                  ($urandom_range(0, 3) == 0) ? 32'd0 : $urandom(),
                  1'($urandom_range(0, 1)), $urandom_range(0, 15) == 0);
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
